song_reader: RTL
================

// Module: song_reader
// PURPOSE
//  Initiator side of the note load/done handshake: walks a song ROM entry by entry, presents
//  {note, duration} to the note player with a one-cycle new_note pulse, then waits for
//  note_done before fetching the next entry. Sits between the top-level play/song controls
//  and the note player; the song ROM is external (1-cycle synchronous read).
// PARAMETERS
//  NOTE_W  6  note code width (0 = rest)
//  DUR_W   6  duration width, in 1/48 s beats
//  IDX_W   5  note index width; 2**IDX_W entries per song
//  SONG_W  2  song select width
// PORTS
//  clk         in   1               system clock; the block's only clock
//  reset       in   1               asynchronous, active-low reset
//  play        in   1               1 = advance through song, 0 = pause
//  song_sel    in   SONG_W          song number, latched on start
//  note_done   in   1               done_with_note from note player
//  rom_addr    out  SONG_W+IDX_W    {song, index} to song ROM
//  rom_data    in   NOTE_W+DUR_W    {note, duration}, valid 1 clk after rom_addr
//  note        out  NOTE_W          note to load
//  duration    out  DUR_W           duration to load
//  new_note    out  1               1-cycle load strobe (drives load_new_note)
//  song_done   out  1               1-cycle pulse at end of song
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, index=0, song=0; all outputs 0.
//  States: IDLE, FETCH, ROMWAIT, ISSUE, GUARD, WAIT_DONE, DONE.
//  IDLE: play=1 -> latch song_sel, index=0, go FETCH. Otherwise stay.
//  FETCH: drive rom_addr={song,index}; next cycle ROMWAIT.
//  ROMWAIT: capture rom_data. If entry == 0 (note=0 AND dur=0): end marker -> DONE.
//   Otherwise register note/duration -> ISSUE.
//  ISSUE: new_note=1 for exactly this cycle -> GUARD.
//  GUARD: one cycle; note_done ignored (player registers the load one cycle late) -> WAIT_DONE.
//  WAIT_DONE: on note_done=1: index==2**IDX_W-1 -> DONE, else index+1 -> FETCH.
//   note_done is sampled only in WAIT_DONE; a level held high advances exactly one entry
//   per visit.
//  DONE: song_done=1 on entry cycle only; stay until play=0, then IDLE.
//  Pause: play=0 freezes FETCH/ROMWAIT/ISSUE transitions (stay in state; ISSUE does not
//   pulse while paused). WAIT_DONE and GUARD still run, since the note player pauses itself.
//  note/duration hold their value from the ISSUE cycle until the next ISSUE; never change
//   while new_note=0 mid-note.
//  A duration=0 entry with note!=0 is issued normally; the player returns done at once.
//  song_sel changes after start are ignored until the next IDLE->FETCH.
//  Reset mid-song aborts immediately; no new_note or song_done is produced.
//  Index arithmetic is IDX_W-bit unsigned; the last entry never wraps to index 0 without
//   going through DONE.
// CONFIGURATION
//  SONG_LOOP_EN defined: at end of song (marker or last index), pulse song_done, set
//   index=0 and go FETCH directly (same latched song). DONE is then reached only via
//   play=0? No: play=0 just pauses as above.
//  SONG_LOOP_EN undefined: behaviour as specified above (DONE, wait for play=0).
// STRUCTURE
//  song_pkg: state encoding constants, NOTE_W/DUR_W/IDX_W/SONG_W defaults, END_MARKER=0.
//  No internal sub-module; song_rom is instantiated by the parent beside this block.
//  Registers: dffr/dffre flops only (state, index, song, note, duration).
// TESTING
//  1 ROM song0 = {(5,3),(7,2),(0,0)}, play=1 -> new_note with 5/3, then 7/2; song_done one
//    cycle after the marker is read; DONE held while play=1.
//  2 note_done held high for 10 cycles in WAIT_DONE -> exactly one index advance; no
//    new_note in the GUARD cycle.
//  3 play=0 during ROMWAIT -> no new_note until play=1; note/duration unchanged.
//  4 song 2 full of 32 non-zero entries -> 32 new_notes, rom_addr ends at 7'h5F, then
//    song_done.
//  5 reset low mid WAIT_DONE -> all outputs 0 asynchronously; after release, play=1
//    restarts at index 0 with a freshly latched song_sel.
//  6 SONG_LOOP_EN, 2-entry song -> song_done pulse, then rom_addr returns to
//    {song,5'd0}, playback continues.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song reader.
//   - default widths for note code, duration, note index and song select
//   - END_MARKER: the all-zero ROM entry that terminates a song
//   - state_e: state encoding of the song_reader sequencer
package song_pkg;

  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 6;
  localparam int IDX_W_DEF  = 5;
  localparam int SONG_W_DEF = 2;

  localparam int END_MARKER = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ROMWAIT   = 3'd2,
    S_ISSUE     = 3'd3,
    S_GUARD     = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/song_reader.sv
// song_reader: walks a song ROM entry by entry and hands {note, duration} to the
// note player with a one-cycle new_note strobe, then waits for note_done before
// fetching the next entry.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   play       1 = advance through the song, 0 = pause
//   song_sel   song number, latched when playback starts from IDLE
//   note_done  done_with_note from the note player
//   rom_addr   {song, index} to the external song ROM (1-cycle synchronous read)
//   rom_data   {note, duration} returned by the ROM one cycle after rom_addr
//   note       note code to load (0 = rest)
//   duration   duration to load, in 1/48 s beats
//   new_note   one-cycle load strobe
//   song_done  one-cycle pulse at the end of the song
//
// Build option: SONG_LOOP_EN - when defined, the end of a song pulses song_done and
// restarts the same song at index 0 instead of parking in DONE.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | waiting for play; latches song_sel and clears index on start
// FETCH     | rom_addr presented, ROM read in flight
// ROMWAIT   | rom_data valid; end marker finishes the song, else load note
// ISSUE     | new_note high (this is the load cycle)
// GUARD     | player registers the load a cycle late; note_done ignored
// WAIT_DONE | waiting for note_done; advances one entry per visit
// DONE      | song finished; holds until play drops
module song_reader
  import song_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int SONG_W = SONG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic                     note_done,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     new_note,
  output logic                     song_done
);

`ifdef SONG_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0]        IDX_LAST  = '1;
  localparam logic [NOTE_W+DUR_W-1:0] END_ENTRY = (NOTE_W+DUR_W)'(END_MARKER);

  state_e              state_q;
  logic [IDX_W-1:0]    index_q;
  logic [SONG_W-1:0]   song_q;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    dur_q;
  logic                new_note_q;
  logic                song_done_q;

  logic [IDX_W-1:0]    index_d;
  logic                last_idx;

  assign index_d  = index_q + 1'b1;
  assign last_idx = (index_q == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      song_q      <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (play) begin
            song_q  <= song_sel;
            index_q <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (play) state_q <= S_ROMWAIT;
        end
        S_ROMWAIT: begin
          // The address is held while paused, so rom_data stays valid here.
          if (play) begin
            if (rom_data == END_ENTRY) begin
              song_done_q <= 1'b1;
              if (LOOP_EN) begin
                index_q <= '0;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_DONE;
              end
            end else begin
              // Outputs change together with the strobe, never mid-note.
              note_q     <= rom_data[NOTE_W+DUR_W-1:DUR_W];
              dur_q      <= rom_data[DUR_W-1:0];
              new_note_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (play) state_q <= S_GUARD;
        end
        S_GUARD: begin
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (note_done) begin
            if (last_idx) begin
              song_done_q <= 1'b1;
              if (LOOP_EN) begin
                index_q <= '0;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_DONE;
              end
            end else begin
              index_q <= index_d;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (!play) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr  = {song_q, index_q};
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule
